registro_file: RTL and testbench



---
 rtl/registro_file.sv | 68 ++++++
 tb/tb_registro_file.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/registro_file.sv
// Register file: NUM_REGS x DATA_WIDTH, two combinational read ports, one synchronous write
// port sharing address1. Optional write-through forwarding under `REGISTRO_BYPASS_EN.
module registro_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] address1,
   input  logic [ADDR_WIDTH-1:0] address2,
   input  logic                  write,
   output logic [DATA_WIDTH-1:0] data_out1,
   output logic [DATA_WIDTH-1:0] data_out2
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   // One extra bit so NUM_REGS == 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

   logic             in_range1;
   logic             in_range2;
   logic [IDX_W-1:0] idx1;
   logic [IDX_W-1:0] idx2;
   logic             wr_en;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return ({1'b0, a} < NUM_REGS_W);
   endfunction

   assign in_range1 = in_range(address1);
   assign in_range2 = in_range(address2);
   assign idx1      = address1[IDX_W-1:0];
   assign idx2      = address2[IDX_W-1:0];
   assign wr_en     = write && !rst && in_range1;

   always_comb begin
      regs_d = regs_q;
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
      end else if (wr_en) begin
         regs_d[idx1] = data_in;
      end
   end

   always_ff @(posedge clk) begin
      regs_q <= regs_d;
   end

   // Out-of-range reads return zero rather than aliasing onto a real entry.
   always_comb begin
      data_out1 = '0;
      data_out2 = '0;
      if (in_range1) data_out1 = regs_q[idx1];
      if (in_range2) data_out2 = regs_q[idx2];
`ifdef REGISTRO_BYPASS_EN
      if (wr_en) begin
         data_out1 = data_in;
         if (address2 == address1) data_out2 = data_in;
      end
`endif
   end

endmodule

// File: tb/tb_registro_file.sv
// Scoreboard bench for registro_file: stimulus pushes expected port values, a negedge
// monitor pops and compares. Expectations adapt to `REGISTRO_BYPASS_EN.
module tb_registro_file;

   localparam int DW = 32;
   localparam int AW = 16;
   localparam int NR = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] data_in;
   logic [AW-1:0] address1;
   logic [AW-1:0] address2;
   logic          write;
   logic [DW-1:0] data_out1;
   logic [DW-1:0] data_out2;

   registro_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .address1 (address1),
      .address2 (address2),
      .write    (write),
      .data_out1(data_out1),
      .data_out2(data_out2)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         name;
      logic [DW-1:0] e1;
      logic [DW-1:0] e2;
   } exp_t;

   exp_t          sb_q[$];
   int            n_chk  = 0;
   int            n_pass = 0;
   logic [DW-1:0] mdl [NR];

`ifdef REGISTRO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // Monitor: outputs are combinational, so every queued expectation is compared mid-cycle.
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         n_chk++;
         if (data_out1 === e.e1 && data_out2 === e.e2) n_pass++;
         else $display("FAIL %s: got out1=%h out2=%h, want out1=%h out2=%h",
                       e.name, data_out1, data_out2, e.e1, e.e2);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic w, input int a1, input int a2,
                        input logic [DW-1:0] d);
      rst      = r;
      write    = w;
      address1 = AW'(a1);
      address2 = AW'(a2);
      data_in  = d;
   endtask

   task automatic expect_out(input string name, input logic [DW-1:0] e1,
                             input logic [DW-1:0] e2);
      exp_t e;
      e.name = name;
      e.e1   = e1;
      e.e2   = e2;
      sb_q.push_back(e);
   endtask

   // Reads every register through both ports, one pair per cycle, against the model.
   task automatic sweep(input string name);
      for (int i = 0; i < NR; i++) begin
         cyc();
         drive(1'b0, 1'b0, i, NR - 1 - i, 32'h5A5A_5A5A);
         expect_out($sformatf("%s_r%0d", name, i), mdl[i], mdl[NR - 1 - i]);
      end
   endtask

   initial begin
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      drive(1'b1, 1'b0, 0, 0, '0);

      // 1: reset edge, then reads of 5 and 7 are zero
      cyc();
      drive(1'b0, 1'b0, 5, 7, '0);
      expect_out("t1_reset", 32'h0, 32'h0);
      sweep("t1_sweep");

      // 2: write ACEDCAFE to reg4; before the edge only the bypass build forwards it
      cyc();
      drive(1'b0, 1'b1, 4, 9, 32'hACED_CAFE);
      expect_out("t2_pre_edge", BYP ? 32'hACED_CAFE : 32'h0, 32'h0);
      cyc();
      mdl[4] = 32'hACED_CAFE;
      drive(1'b0, 1'b0, 4, 4, 32'hACED_CAFE);
      expect_out("t2_readback", 32'hACED_CAFE, 32'hACED_CAFE);

      // 3: write=0 keeps contents across several edges
      for (int k = 0; k < 3; k++) begin
         cyc();
         drive(1'b0, 1'b0, 3, 4, 32'hDEAD_BEEF);
         expect_out($sformatf("t3_nowrite%0d", k), 32'h0, 32'hACED_CAFE);
      end

      // 4: out-of-range write is dropped, out-of-range read is zero
      cyc();
      drive(1'b0, 1'b1, 40, 4, 32'h1234_5678);
      expect_out("t4_oor_pre", 32'h0, 32'hACED_CAFE);
      cyc();
      drive(1'b0, 1'b0, 40, 8, 32'h1234_5678);
      expect_out("t4_oor_post", 32'h0, 32'h0);
      sweep("t4_sweep");

      // Boundary: last register writes, first out-of-range address reads zero
      cyc();
      drive(1'b0, 1'b1, NR - 1, NR, 32'h1F1F_1F1F);
      expect_out("bnd_pre", BYP ? 32'h1F1F_1F1F : 32'h0, 32'h0);
      cyc();
      mdl[NR - 1] = 32'h1F1F_1F1F;
      drive(1'b0, 1'b0, NR, NR - 1, 32'h0);
      expect_out("bnd_post", 32'h0, 32'h1F1F_1F1F);

      // 5: reset beats a simultaneous write
      cyc();
      drive(1'b1, 1'b1, 4, NR - 1, 32'hFFFF_FFFF);
      expect_out("t5_pre_edge", 32'hACED_CAFE, 32'h1F1F_1F1F);
      cyc();
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      drive(1'b0, 1'b0, 4, NR - 1, 32'hFFFF_FFFF);
      expect_out("t5_after_rst", 32'h0, 32'h0);
      sweep("t5_sweep");

      // 6: read-during-write on the same register through both ports
      cyc();
      drive(1'b0, 1'b1, 6, 6, 32'h0BAD_F00D);
      expect_out("t6_rdw", BYP ? 32'h0BAD_F00D : 32'h0, BYP ? 32'h0BAD_F00D : 32'h0);
      cyc();
      mdl[6] = 32'h0BAD_F00D;
      drive(1'b0, 1'b0, 6, 6, 32'h0);
      expect_out("t6_post", 32'h0BAD_F00D, 32'h0BAD_F00D);
      sweep("t6_sweep");

      cyc();
      for (int k = 0; k < 4 && sb_q.size() > 0; k++) @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         n_chk++;
         $display("FAIL drain: got %0d pending, want 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

endmodule
